sprite_blitter: RTL and testbench

// - Reader side of the character sprite ROM: walks one sprite's rows (ROM row = 32-bit word, MSB = leftmost pixel).
// - Serialises the sprite into a pixel stream of (x, y, on) beats for the framebuffer writer in fb_v2.
// - One sprite per start request, placed at a caller-given origin, with valid/ready backpressure.

---
 rtl/sprite_blitter.sv | 131 +++++++++++++
 tb/tb_sprite_blitter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_blitter.sv
// Sprite ROM reader: walks one sprite row by row and serialises it into (x, y, on) pixel beats.
// Optional build macro SPRITE_TRANSPARENT_EN drops beats for 0 pixels.
module sprite_blitter #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int SPRITE_ROWS = 32,
    parameter int NUM_SPRITES = 4,
    parameter int COORD_W     = 10,
    localparam int IDX_W      = $clog2(NUM_SPRITES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IDX_W-1:0]      spr_idx,
    input  logic [COORD_W-1:0]    x0,
    input  logic [COORD_W-1:0]    y0,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  px_valid,
    input  logic                  px_ready,
    output logic [COORD_W-1:0]    px_x,
    output logic [COORD_W-1:0]    px_y,
    output logic                  px_on
);

    localparam int COL_W = $clog2(DATA_WIDTH);
    localparam int ROW_W = $clog2(SPRITE_ROWS);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(DATA_WIDTH - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(SPRITE_ROWS - 1);

    typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

    state_t                state, next_state;
    logic [IDX_W-1:0]      spr_q;
    logic [COORD_W-1:0]    x0_q, y0_q;
    logic [ROW_W-1:0]      row;
    logic [COL_W-1:0]      col;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  pix_bit, emit, on_val, adv;

    function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [IDX_W-1:0] idx,
                                                      input logic [ROW_W-1:0] r);
        return ADDR_WIDTH'(int'(idx) * SPRITE_ROWS + int'(r));
    endfunction

    // Coordinates come straight from registers, so they cannot move while a beat is stalled.
    assign px_x    = x0_q + COORD_W'(col);
    assign px_y    = y0_q + COORD_W'(row);
    assign pix_bit = shreg[LAST_COL - col];

`ifdef SPRITE_TRANSPARENT_EN
    assign emit   = pix_bit;
    assign on_val = 1'b1;
`else
    assign emit   = 1'b1;
    assign on_val = pix_bit;
`endif

    // NOTE: every output of an always_comb gets a default first; a path that leaves one unassigned infers a latch.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        px_valid   = 1'b0;
        px_on      = 1'b0;
        adv        = 1'b0;
        case (state)
            IDLE: if (start) next_state = FETCH;
            FETCH: begin
                busy       = 1'b1;
                next_state = SHIFT;
            end
            SHIFT: begin
                busy     = 1'b1;
                px_valid = emit;
                px_on    = emit & on_val;
                // A suppressed (transparent) pixel advances without waiting for the writer.
                adv      = (emit & px_ready) | ~emit;
                if (adv && col == LAST_COL)
                    next_state = (row == LAST_ROW) ? DONE : FETCH;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            spr_q    <= '0;
            x0_q     <= '0;
            y0_q     <= '0;
            row      <= '0;
            col      <= '0;
            shreg    <= '0;
            rom_addr <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: if (start) begin
                    spr_q    <= spr_idx;
                    x0_q     <= x0;
                    y0_q     <= y0;
                    row      <= '0;
                    col      <= '0;
                    rom_addr <= addr_of(spr_idx, '0);
                end
                FETCH: begin
                    shreg <= rom_data;
                    col   <= '0;
                end
                SHIFT: if (adv) begin
                    col <= col + COL_W'(1);
                    // Address for the next row is registered here so it is stable throughout FETCH.
                    if (col == LAST_COL && row != LAST_ROW) begin
                        row      <= row + ROW_W'(1);
                        rom_addr <= addr_of(spr_q, row + ROW_W'(1));
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: ROM model, beat capture and a reference beat list built from the ROM.
// Works in both the default build and with SPRITE_TRANSPARENT_EN defined.
module tb_sprite_blitter;

    localparam int AW   = 8;
    localparam int DW   = 32;
    localparam int ROWS = 32;
    localparam int CW   = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    spr_idx = '0;
    logic [CW-1:0] x0 = '0, y0 = '0;
    logic          busy, done;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic          px_valid;
    logic          px_ready = 1'b1;
    logic [CW-1:0] px_x, px_y;
    logic          px_on;

    logic [DW-1:0] rom [256];
    assign rom_data = rom[rom_addr];

    sprite_blitter dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .spr_idx  (spr_idx),
        .x0       (x0),
        .y0       (y0),
        .busy     (busy),
        .done     (done),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .px_valid (px_valid),
        .px_ready (px_ready),
        .px_x     (px_x),
        .px_y     (px_y),
        .px_on    (px_on)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [CW-1:0] bx [1024], by [1024], ex [1024], ey [1024];
    logic          bo [1024], eo [1024];
    int nb, ne, exp_beats;
    int cyc, beat_err, addr_err, stab_err, done_cnt, n_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic build_expected(input logic [1:0] idx, input logic [CW-1:0] x, input logic [CW-1:0] y);
        logic [DW-1:0] w;
        ne = 0;
        for (int r = 0; r < ROWS; r++) begin
            w = rom[AW'(int'(idx) * ROWS + r)];
            for (int c = 0; c < DW; c++) begin
`ifdef SPRITE_TRANSPARENT_EN
                if (w[DW-1-c]) begin
                    ex[ne] = x + CW'(c); ey[ne] = y + CW'(r); eo[ne] = 1'b1; ne++;
                end
`else
                ex[ne] = x + CW'(c); ey[ne] = y + CW'(r); eo[ne] = w[DW-1-c]; ne++;
`endif
            end
        end
`ifdef SPRITE_TRANSPARENT_EN
        exp_beats = ne;
`else
        exp_beats = 1024;
`endif
    endtask

    task automatic run_blit(input logic [1:0] idx, input logic [CW-1:0] x, input logic [CW-1:0] y,
                            input bit rnd_ready, input int mid_start_at);
        logic [AW-1:0] last_addr;
        logic [CW-1:0] hx, hy;
        logic          ho, held;
        nb = 0; beat_err = 0; addr_err = 0; stab_err = 0; done_cnt = 0; n_addr = 0;
        last_addr = '0; held = 1'b0; hx = '0; hy = '0; ho = 1'b0;
        build_expected(idx, x, y);
        @(negedge clk);
        spr_idx = idx; x0 = x; y0 = y; start = 1'b1; px_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 6000) begin
            if (held && (px_valid !== 1'b1 || px_x !== hx || px_y !== hy || px_on !== ho))
                stab_err++;
            if (busy === 1'b1 && (n_addr == 0 || rom_addr !== last_addr)) begin
                if (n_addr >= 32 || rom_addr !== AW'(int'(idx) * ROWS + n_addr)) addr_err++;
                last_addr = rom_addr;
                n_addr++;
            end
            if (cyc == mid_start_at) begin
                start = 1'b1; spr_idx = ~idx; x0 = x + CW'(5); y0 = y + CW'(7);
            end else begin
                start = 1'b0;
            end
            px_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            held = px_valid && !px_ready;
            hx = px_x; hy = px_y; ho = px_on;
            if (px_valid === 1'b1 && px_ready) begin
                if (nb < 1024) begin
                    bx[nb] = px_x; by[nb] = px_y; bo[nb] = px_on;
                end
                nb++;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        px_ready = 1'b1;
        if (done === 1'b1) done_cnt++;
        @(negedge clk);
        if (done === 1'b1) done_cnt++;
        for (int i = 0; i < nb && i < ne && i < 1024; i++)
            if (bx[i] !== ex[i] || by[i] !== ey[i] || bo[i] !== eo[i]) beat_err++;
    endtask

    int cnt_row11, cnt_blank, bad_row11, dones_after_rst;

    initial begin
        for (int a = 0; a < 256; a++) begin
            logic [7:0] b;
            b = 8'(a);
            rom[a] = {b, ~b, b ^ 8'h5A, b + 8'h33};
        end
        for (int r = 0; r < ROWS; r++) begin
            if (r < 5 || r == 10) rom[r] = 32'h0;
            else if (r == 5)      rom[r] = 32'h1234_5678;
            else if (r == 11)     rom[r] = 32'h0001_8000;
            else                  rom[r] = 32'hA5C3_3C5A ^ (32'(r) * 32'h0101_0111);
        end

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_valid", 32'(px_valid), 0);
        check("rst_addr", 32'(rom_addr), 0);
        check("rst_px_xy_on", {11'(px_x), 11'(px_y), 10'(px_on)}, 0);

        // Baseline blit with the writer always ready.
        run_blit(2'd0, 10'd100, 10'd50, 1'b0, -1);
        check("a_beats", nb, exp_beats);
        check("a_beat_data", beat_err, 0);
        check("a_addr_seq", addr_err, 0);
        check("a_addr_count", n_addr, 32);
        check("a_cycles", cyc, 1056);
        check("a_done_once", done_cnt, 1);
        check("a_busy_after", 32'(busy), 0);
`ifdef SPRITE_TRANSPARENT_EN
        cnt_row11 = 0; cnt_blank = 0; bad_row11 = 0;
        for (int i = 0; i < nb && i < 1024; i++) begin
            if (by[i] == 10'd61) begin
                cnt_row11++;
                if (bx[i] != 10'd115 && bx[i] != 10'd116) bad_row11++;
            end
            if ((by[i] >= 10'd50 && by[i] <= 10'd54) || by[i] == 10'd60) cnt_blank++;
            if (bo[i] !== 1'b1) bad_row11++;
        end
        check("t_row11_beats", cnt_row11, 2);
        check("t_row11_cols_on", bad_row11, 0);
        check("t_blank_rows", cnt_blank, 0);
`else
        check("a_first_x", 32'(bx[0]), 100);
        check("a_first_y", 32'(by[0]), 50);
        check("a_103_55_xy", {16'(bx[5*32+3]), 16'(by[5*32+3])}, {16'd103, 16'd55});
        check("a_103_55_on", 32'(bo[5*32+3]), 1);
        check("a_100_55_x", 32'(bx[5*32]), 100);
        check("a_100_55_on", 32'(bo[5*32]), 0);
`endif

        // Same blit with a writer that stalls about half the time.
        run_blit(2'd0, 10'd100, 10'd50, 1'b1, -1);
        check("b_beats", nb, exp_beats);
        check("b_beat_data", beat_err, 0);
        check("b_hold_stable", stab_err, 0);
        check("b_done_once", done_cnt, 1);

        // Last sprite with coordinates that wrap on both axes.
        run_blit(2'd3, 10'd1020, 10'd1023, 1'b0, -1);
        check("c_addr_seq", addr_err, 0);
        check("c_addr_count", n_addr, 32);
        check("c_beat_data", beat_err, 0);
        check("c_beats", nb, exp_beats);
`ifndef SPRITE_TRANSPARENT_EN
        check("c_col4_x_wrap", 32'(bx[4]), 0);
        check("c_row0_y", 32'(by[4]), 1023);
        check("c_row1_y_wrap", 32'(by[32]), 0);
`endif

        // A start pulse in the middle of a blit must be ignored.
        run_blit(2'd1, 10'd300, 10'd200, 1'b0, 200);
        check("d_beats", nb, exp_beats);
        check("d_beat_data", beat_err, 0);
        check("d_done_once", done_cnt, 1);

        // Reset around row 7 abandons the sprite without a done pulse.
        @(negedge clk);
        spr_idx = 2'd2; x0 = 10'd10; y0 = 10'd20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones_after_rst = 0;
        repeat (7 * 33 + 10) begin
            if (done === 1'b1) dones_after_rst++;
            @(negedge clk);
        end
        check("e_busy_mid", 32'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("e_rst_busy", 32'(busy), 0);
        check("e_rst_valid", 32'(px_valid), 0);
        check("e_rst_addr", 32'(rom_addr), 0);
        repeat (40) begin
            if (done === 1'b1) dones_after_rst++;
            @(negedge clk);
        end
        check("e_no_done", dones_after_rst, 0);
        run_blit(2'd2, 10'd10, 10'd20, 1'b0, -1);
        check("e_restart_beats", nb, exp_beats);
        check("e_restart_data", beat_err, 0);
        check("e_restart_done", done_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
